spi_slave_par: RTL and testbench

SPI_SLAVE_PAR -- requirements
Module: spi_slave_par

---
 rtl/spi_slave_par.sv | 166 ++++++++++++++++
 tb/tb_spi_slave_par.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_par.sv
// SPI slave with oversampled pins, configurable mode and bit order, show-ahead receive FIFO
// and a transmit holding register that drains to zeros when not refreshed.
module spi_slave_par #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          iSPIClk,
  input  logic                          iSPIMOSI,
  input  logic                          iSPICS,
  output logic                          oSPIMISO,
  output logic [WIDTH-1:0]              oRx,
  output logic                          oRxValid,
  input  logic                          iRxRead,
  output logic [$clog2(FIFO_DEPTH):0]   oRxCount,
  output logic                          oOverflow,
  input  logic                          iOvfClear,
  output logic                          oFrameErr,
  input  logic [WIDTH-1:0]              iTx,
  input  logic                          iTxLoad
);

  localparam int   AW        = $clog2(FIFO_DEPTH);
  localparam int   CW        = $clog2(WIDTH);
  localparam logic SCLK_IDLE = (CPOL != 0);
  localparam bit   SAMP_RISE = ((CPOL ^ CPHA) % 2) == 0;
  localparam bit   MSBF      = (MSB_FIRST != 0);

  logic sclk_s1, sclk_s2, sclk_d;
  logic mosi_s1, mosi_s2, mosi_d;
  logic cs_s1, cs_s2, cs_d;
  logic [1:0] fill;
  logic armed;

  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] rx_sh, rx_next, push_word;
  logic             push_req;
  logic [WIDTH-1:0] tx_hold, tx_sh;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] rx_last;

  logic active, rise, fall, samp, shft, last, cs_fall, cs_rise;
  logic tx_load, tx_shift, full, pop, wr, ovf_set;

  // Pin synchronizers; armed only after CS has been seen high with the chain refilled,
  // so a frame already in progress at reset release is ignored.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sclk_s1 <= SCLK_IDLE;
      sclk_s2 <= SCLK_IDLE;
      sclk_d  <= SCLK_IDLE;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      mosi_d  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sclk_s1 <= iSPIClk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= iSPIMOSI;
      mosi_s2 <= mosi_s1;
      mosi_d  <= mosi_s2;
      cs_s1   <= iSPICS;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      fill    <= {fill[0], 1'b1};
      if (fill[1] && cs_s2) armed <= 1'b1;
    end
  end

  always_comb begin
    active   = armed & ~cs_s2;
    rise     = sclk_s2 & ~sclk_d;
    fall     = ~sclk_s2 & sclk_d;
    samp     = active & (SAMP_RISE ? rise : fall);
    shft     = active & (SAMP_RISE ? fall : rise);
    last     = (bitcnt == CW'(WIDTH-1));
    cs_fall  = armed & ~cs_s2 & cs_d;
    cs_rise  = armed & cs_s2 & ~cs_d;
    rx_next  = MSBF ? {rx_sh[WIDTH-2:0], mosi_d} : {mosi_d, rx_sh[WIDTH-1:1]};
    // CPHA=0 must present bit 0 before the first leading edge, so it loads at CS fall / wrap
    // and skips the trailing edge right after a wrap.
    tx_load  = (CPHA == 0) ? (cs_fall | (samp & last)) : (shft & (bitcnt == '0));
    tx_shift = shft & (bitcnt != '0);
    full     = (count == (AW+1)'(FIFO_DEPTH));
    pop      = iRxRead & (count != '0);
    wr       = push_req & (~full | pop);
    ovf_set  = push_req & full & ~pop;
  end

  // Bit counter and frame control
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      bitcnt    <= '0;
      push_req  <= 1'b0;
      oFrameErr <= 1'b0;
    end else begin
      push_req  <= samp & last;
      oFrameErr <= cs_rise & (bitcnt != '0);
      if (!active)  bitcnt <= '0;
      else if (samp) bitcnt <= last ? '0 : bitcnt + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (samp)        rx_sh     <= rx_next;
    if (samp & last) push_word <= rx_next;
    if (wr)          mem[wptr] <= push_word;
  end

  // Transmit path; the holding register is consumed by each load unless refreshed.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_hold <= '0;
      tx_sh   <= '0;
    end else begin
      if (tx_load)       tx_sh <= tx_hold;
      else if (tx_shift) tx_sh <= MSBF ? (tx_sh << 1) : (tx_sh >> 1);
      if (iTxLoad)       tx_hold <= iTx;
      else if (tx_load)  tx_hold <= '0;
    end
  end

  // Receive FIFO
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rx_last   <= '0;
      oOverflow <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr    <= rptr + 1'b1;
        rx_last <= mem[rptr];
      end
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)        oOverflow <= 1'b1;
      else if (iOvfClear) oOverflow <= 1'b0;
    end
  end

  always_comb begin
    oSPIMISO = active & (MSBF ? tx_sh[WIDTH-1] : tx_sh[0]);
    oRx      = (count != '0) ? mem[rptr] : rx_last;
    oRxValid = (count != '0);
    oRxCount = count;
  end

endmodule

// File: tb/tb_spi_slave_par.sv
// Directed bench for spi_slave_par: mode 0 MSB-first instance and mode 3 LSB-first instance.
module tb_spi_slave_par;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  always #5 sysclk = ~sysclk;

  logic       sck0, mosi0, cs0, miso0, vld0, rd0, ovf0, ovfclr0, ferr0, txld0;
  logic [7:0] rx0, tx0;
  logic [2:0] cnt0;
  logic       sck3, mosi3, cs3, miso3, vld3, rd3, ovf3, ovfclr3, ferr3, txld3;
  logic [7:0] rx3, tx3;
  logic [2:0] cnt3;

  int total = 0;
  int bad   = 0;

  spi_slave_par dut0 (
    .sysclk(sysclk), .reset(reset), .iSPIClk(sck0), .iSPIMOSI(mosi0), .iSPICS(cs0),
    .oSPIMISO(miso0), .oRx(rx0), .oRxValid(vld0), .iRxRead(rd0), .oRxCount(cnt0),
    .oOverflow(ovf0), .iOvfClear(ovfclr0), .oFrameErr(ferr0), .iTx(tx0), .iTxLoad(txld0)
  );

  spi_slave_par #(.CPOL(1), .CPHA(1), .MSB_FIRST(0)) dut3 (
    .sysclk(sysclk), .reset(reset), .iSPIClk(sck3), .iSPIMOSI(mosi3), .iSPICS(cs3),
    .oSPIMISO(miso3), .oRx(rx3), .oRxValid(vld3), .iRxRead(rd3), .oRxCount(cnt3),
    .oOverflow(ovf3), .iOvfClear(ovfclr3), .oFrameErr(ferr3), .iTx(tx3), .iTxLoad(txld3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(posedge sysclk);
    #1;
  endtask

  // mode: 0 plain, 1 latency check after last edge, 2 pop coinciding with the push
  task automatic xfer(input bit m3, input logic [7:0] word, input int nbits, input int mode,
                      output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!m3) begin
        mosi0 = word[7-i];
        half();
        got[7-i] = miso0;
        sck0 = 1'b1;
        if (mode == 1 && i == nbits-1) begin
          repeat (3) @(posedge sysclk);
          @(negedge sysclk);
          check("lat3", 32'(vld0), 0);
          @(posedge sysclk);
          @(negedge sysclk);
          check("lat4", 32'(vld0), 1);
          repeat (4) @(posedge sysclk);
          #1;
        end else if (mode == 2 && i == nbits-1) begin
          repeat (3) @(posedge sysclk);
          #1 rd0 = 1'b1;
          @(posedge sysclk);
          #1 rd0 = 1'b0;
          repeat (4) @(posedge sysclk);
          #1;
        end else begin
          half();
        end
        sck0 = 1'b0;
      end else begin
        sck3  = 1'b0;
        mosi3 = word[i];
        half();
        got[i] = miso3;
        sck3 = 1'b1;
        half();
      end
    end
  endtask

  task automatic pop0(input string tag, input logic [7:0] exp);
    check(tag, 32'(rx0), 32'(exp));
    rd0 = 1'b1;
    @(posedge sysclk);
    #1 rd0 = 1'b0;
  endtask

  logic [7:0] g;
  logic [7:0] w5 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  int n;

  initial begin
    sck0 = 1'b0; mosi0 = 1'b0; cs0 = 1'b1; rd0 = 1'b0; ovfclr0 = 1'b0; tx0 = '0; txld0 = 1'b0;
    sck3 = 1'b1; mosi3 = 1'b0; cs3 = 1'b1; rd3 = 1'b0; ovfclr3 = 1'b0; tx3 = '0; txld3 = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_cnt", 32'(cnt0), 0);
    check("rst_vld", 32'(vld0), 0);
    check("rst_rx", 32'(rx0), 0);
    check("rst_ovf", 32'(ovf0), 0);
    check("rst_ferr", 32'(ferr0), 0);
    check("rst_miso", 32'(miso0), 0);
    check("rst_vld3", 32'(vld3), 0);
    reset = 1'b0;
    repeat (4) @(posedge sysclk);
    #1;

    // single word, mode 0, with latency and MISO
    tx0 = 8'h5A; txld0 = 1'b1;
    @(posedge sysclk);
    #1 txld0 = 1'b0;
    cs0 = 1'b0; half();
    xfer(1'b0, 8'hA5, 8, 1, g);
    half(); cs0 = 1'b1; half();
    check("rx_a5", 32'(rx0), 32'hA5);
    check("cnt_a5", 32'(cnt0), 1);
    check("miso_5a", 32'(g), 32'h5A);
    pop0("pop_a5", 8'hA5);
    check("cnt_after_pop", 32'(cnt0), 0);
    check("vld_after_pop", 32'(vld0), 0);
    check("rx_hold", 32'(rx0), 32'hA5);

    // five back-to-back words into a 4-deep FIFO
    cs0 = 1'b0; half();
    for (int k = 0; k < 5; k++) begin
      xfer(1'b0, w5[k], 8, 0, g);
      if (k == 0) check("miso_zero", 32'(g), 0);
    end
    half(); cs0 = 1'b1; half();
    check("ovf_cnt", 32'(cnt0), 4);
    check("ovf_set", 32'(ovf0), 1);
    for (int k = 0; k < 4; k++) pop0("ovf_rd", w5[k]);
    check("ovf_empty", 32'(vld0), 0);
    ovfclr0 = 1'b1;
    @(posedge sysclk);
    #1 ovfclr0 = 1'b0;
    check("ovf_clr", 32'(ovf0), 0);

    // full FIFO with a pop coinciding with the fifth push
    cs0 = 1'b0; half();
    for (int k = 1; k <= 4; k++) xfer(1'b0, 8'(k), 8, 0, g);
    xfer(1'b0, 8'h05, 8, 2, g);
    half(); cs0 = 1'b1; half();
    check("full_cnt", 32'(cnt0), 4);
    check("full_ovf", 32'(ovf0), 0);
    for (int k = 2; k <= 5; k++) pop0("full_rd", 8'(k));

    // CS rises after 3 bits
    cs0 = 1'b0; half();
    xfer(1'b0, 8'hE0, 3, 0, g);
    half(); cs0 = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge sysclk);
      if (ferr0) n++;
    end
    check("ferr_pulse", 32'(n), 1);
    check("ferr_cnt", 32'(cnt0), 0);
    @(posedge sysclk);
    #1;
    cs0 = 1'b0; half();
    xfer(1'b0, 8'hC3, 8, 0, g);
    half(); cs0 = 1'b1; half();
    check("ferr_next_cnt", 32'(cnt0), 1);
    pop0("ferr_next", 8'hC3);

    // reset after 5 bits of a frame
    cs0 = 1'b0; half();
    xfer(1'b0, 8'hF0, 5, 0, g);
    reset = 1'b1;
    #1;
    check("mrst_rx", 32'(rx0), 0);
    check("mrst_cnt", 32'(cnt0), 0);
    check("mrst_vld", 32'(vld0), 0);
    check("mrst_miso", 32'(miso0), 0);
    check("mrst_ferr", 32'(ferr0), 0);
    @(posedge sysclk);
    #1 reset = 1'b0;
    repeat (4) @(posedge sysclk);
    #1;
    xfer(1'b0, 8'hFF, 8, 0, g);
    half();
    check("mrst_ignore", 32'(cnt0), 0);
    cs0 = 1'b1; half();
    cs0 = 1'b0; half();
    xfer(1'b0, 8'h96, 8, 0, g);
    half(); cs0 = 1'b1; half();
    check("mrst_cnt2", 32'(cnt0), 1);
    check("mrst_rx2", 32'(rx0), 32'h96);
    check("mrst_ferr2", 32'(ferr0), 0);

    // mode 3, LSB first
    tx3 = 8'h3C; txld3 = 1'b1;
    @(posedge sysclk);
    #1 txld3 = 1'b0;
    cs3 = 1'b0; half();
    xfer(1'b1, 8'h81, 8, 0, g);
    half(); cs3 = 1'b1; half();
    check("m3_rx", 32'(rx3), 32'h81);
    check("m3_vld", 32'(vld3), 1);
    check("m3_cnt", 32'(cnt3), 1);
    check("m3_miso", 32'(g), 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
